// File: rtl/alu_execute_stage.sv
// Execute stage: single-cycle ALU ops plus an iterative shift-add multiplier, with the
// branch target/decision and a one-entry valid/ready output slot toward the D-cache stage.
module alu_execute_stage #(
  parameter int WIDTH    = 32,
  parameter int PC_WIDTH = 32
) (
  input  logic                clock,
  input  logic                resetN,
  input  logic                inValid,
  output logic                inReady,
  input  logic [3:0]          aluOp,
  input  logic [WIDTH-1:0]    readData1,
  input  logic [WIDTH-1:0]    readData2,
  input  logic [PC_WIDTH-1:0] pcCurrent,
  input  logic [PC_WIDTH-1:0] pcOffsetFilled,
  input  logic [WIDTH-1:0]    writeDataIn,
  input  logic [4:0]          writeRegIn,
  input  logic                regWriteIn,
  input  logic                memReadIn,
  input  logic                memWriteIn,
  input  logic                branchIn,
  input  logic                uncondBranchIn,
  output logic                outValid,
  input  logic                outReady,
  output logic [WIDTH-1:0]    aluResult,
  output logic                zeroFlag,
  output logic [PC_WIDTH-1:0] branchTarget,
  output logic                branchTaken,
  output logic [WIDTH-1:0]    writeDataOut,
  output logic [4:0]          writeRegOut,
  output logic                regWriteOut,
  output logic                memReadOut,
  output logic                memWriteOut
);

  localparam logic [3:0] OP_AND   = 4'b0000;
  localparam logic [3:0] OP_ORR   = 4'b0001;
  localparam logic [3:0] OP_ADD   = 4'b0010;
  localparam logic [3:0] OP_SUB   = 4'b0110;
  localparam logic [3:0] OP_PASSB = 4'b0111;
  localparam logic [3:0] OP_MUL   = 4'b1000;
  localparam logic [3:0] OP_LSL   = 4'b1001;
  localparam logic [3:0] OP_LSR   = 4'b1010;
  localparam logic [3:0] OP_EOR   = 4'b1011;

  localparam int CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic {
    S_IDLE,
    S_MUL
  } state_t;

  typedef struct packed {
    logic [PC_WIDTH-1:0] target;
    logic [WIDTH-1:0]    wdata;
    logic [4:0]          wreg;
    logic                reg_write;
    logic                mem_read;
    logic                mem_write;
    logic                branch;
    logic                uncond;
  } ctrl_t;

  state_t              state_q, state_d;
  logic [CNT_W-1:0]    mul_cnt_q;
  logic [WIDTH-1:0]    mul_acc_q;
  logic [WIDTH-1:0]    mcand_q;
  logic [WIDTH-1:0]    mplier_q;
  ctrl_t               mul_ctrl_q;

  logic                out_valid_q;
  logic [WIDTH-1:0]    result_q;
  logic                zero_q;
  logic [PC_WIDTH-1:0] target_q;
  logic                taken_q;
  logic [WIDTH-1:0]    wdata_q;
  logic [4:0]          wreg_q;
  logic                reg_write_q;
  logic                mem_read_q;
  logic                mem_write_q;

  logic                slot_free;
  logic                accept;
  logic                is_mul;
  ctrl_t               in_ctrl;
  logic [6:0]          shamt;
  logic                shift_oob;
  logic [WIDTH-1:0]    alu_result;
  logic [WIDTH-1:0]    mul_step;
  logic                mul_last;
  logic                mul_finished;
  logic [WIDTH-1:0]    mul_product;
  logic                load_en;
  logic [WIDTH-1:0]    ld_result;
  ctrl_t               ld_ctrl;
  logic                ld_zero;
  logic                ld_taken;

  // The slot can take a new entry when empty or when its current entry leaves this edge.
  assign slot_free = !out_valid_q || outReady;
  assign inReady   = resetN && (state_q == S_IDLE) && slot_free;
  assign accept    = inValid && inReady;
  assign is_mul    = (aluOp == OP_MUL);

  assign in_ctrl.target    = pcCurrent + (pcOffsetFilled << 2);
  assign in_ctrl.wdata     = writeDataIn;
  assign in_ctrl.wreg      = writeRegIn;
  assign in_ctrl.reg_write = regWriteIn;
  assign in_ctrl.mem_read  = memReadIn;
  assign in_ctrl.mem_write = memWriteIn;
  assign in_ctrl.branch    = branchIn;
  assign in_ctrl.uncond    = uncondBranchIn;

  assign shamt     = {1'b0, readData2[5:0]};
  assign shift_oob = (shamt >= 7'(WIDTH));

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    alu_result = '0;
    case (aluOp)
      OP_AND:   alu_result = readData1 & readData2;
      OP_ORR:   alu_result = readData1 | readData2;
      OP_ADD:   alu_result = readData1 + readData2;
      OP_SUB:   alu_result = readData1 - readData2;
      OP_PASSB: alu_result = readData2;
      OP_LSL:   alu_result = shift_oob ? '0 : (readData1 << shamt);
      OP_LSR:   alu_result = shift_oob ? '0 : (readData1 >> shamt);
      OP_EOR:   alu_result = readData1 ^ readData2;
      default:  alu_result = '0;
    endcase
  end

  // Multiplicand shifts left and multiplier right, so bit 0 always selects the current term.
  assign mul_step     = mul_acc_q + (mplier_q[0] ? mcand_q : '0);
  assign mul_last     = (mul_cnt_q == CNT_W'(WIDTH - 1));
  assign mul_finished = (mul_cnt_q == CNT_W'(WIDTH));
  assign mul_product  = mul_finished ? mul_acc_q : mul_step;

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept && is_mul) state_d = S_MUL;
      S_MUL:   if ((mul_last || mul_finished) && slot_free) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    load_en   = 1'b0;
    ld_result = alu_result;
    ld_ctrl   = in_ctrl;
    if (state_q == S_MUL) begin
      ld_result = mul_product;
      ld_ctrl   = mul_ctrl_q;
      load_en   = (mul_last || mul_finished) && slot_free;
    end else begin
      load_en   = accept && !is_mul;
    end
  end

  assign ld_zero  = (ld_result == '0);
  assign ld_taken = ld_ctrl.uncond | (ld_ctrl.branch & ld_zero);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      state_q    <= S_IDLE;
      mul_cnt_q  <= '0;
      mul_acc_q  <= '0;
      mcand_q    <= '0;
      mplier_q   <= '0;
      mul_ctrl_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept && is_mul) begin
        mul_cnt_q  <= '0;
        mul_acc_q  <= '0;
        mcand_q    <= readData1;
        mplier_q   <= readData2;
        mul_ctrl_q <= in_ctrl;
      end else if (state_q == S_MUL && !mul_finished) begin
        mul_cnt_q <= mul_cnt_q + 1'b1;
        mul_acc_q <= mul_step;
        mcand_q   <= mcand_q << 1;
        mplier_q  <= mplier_q >> 1;
      end
    end
  end

  always_ff @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      out_valid_q <= 1'b0;
      result_q    <= '0;
      zero_q      <= 1'b0;
      target_q    <= '0;
      taken_q     <= 1'b0;
      wdata_q     <= '0;
      wreg_q      <= '0;
      reg_write_q <= 1'b0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
    end else if (load_en) begin
      out_valid_q <= 1'b1;
      result_q    <= ld_result;
      zero_q      <= ld_zero;
      target_q    <= ld_ctrl.target;
      taken_q     <= ld_taken;
      wdata_q     <= ld_ctrl.wdata;
      wreg_q      <= ld_ctrl.wreg;
      reg_write_q <= ld_ctrl.reg_write;
      mem_read_q  <= ld_ctrl.mem_read;
      mem_write_q <= ld_ctrl.mem_write;
    end else if (out_valid_q && outReady) begin
      out_valid_q <= 1'b0;
    end
  end

  assign outValid     = out_valid_q;
  assign aluResult    = result_q;
  assign zeroFlag     = zero_q;
  assign branchTarget = target_q;
  assign branchTaken  = taken_q;
  assign writeDataOut = wdata_q;
  assign writeRegOut  = wreg_q;
  assign regWriteOut  = reg_write_q;
  assign memReadOut   = mem_read_q;
  assign memWriteOut  = mem_write_q;

endmodule

// File: tb/tb_alu_execute_stage.sv
// Bench for alu_execute_stage: directed vectors, a transaction-level reference model compared
// every cycle, and literal expectations pinning the key scenarios.
module tb_alu_execute_stage;

  localparam int W = 32;

  logic          clock = 1'b0;
  logic          resetN = 1'b0;
  logic          inValid = 1'b0;
  logic          outReady = 1'b1;
  logic [3:0]    aluOp = 4'd0;
  logic [31:0]   readData1 = '0, readData2 = '0, pcCurrent = '0, pcOffsetFilled = '0;
  logic [31:0]   writeDataIn = '0;
  logic [4:0]    writeRegIn = '0;
  logic          regWriteIn = 0, memReadIn = 0, memWriteIn = 0, branchIn = 0, uncondBranchIn = 0;
  logic          inReady, outValid, zeroFlag, branchTaken;
  logic          regWriteOut, memReadOut, memWriteOut;
  logic [31:0]   aluResult, branchTarget, writeDataOut;
  logic [4:0]    writeRegOut;

  int n_cmp = 0;
  int n_err = 0;

  alu_execute_stage #(.WIDTH(W), .PC_WIDTH(32)) dut (
    .clock(clock), .resetN(resetN), .inValid(inValid), .inReady(inReady), .aluOp(aluOp),
    .readData1(readData1), .readData2(readData2), .pcCurrent(pcCurrent),
    .pcOffsetFilled(pcOffsetFilled), .writeDataIn(writeDataIn), .writeRegIn(writeRegIn),
    .regWriteIn(regWriteIn), .memReadIn(memReadIn), .memWriteIn(memWriteIn),
    .branchIn(branchIn), .uncondBranchIn(uncondBranchIn), .outValid(outValid),
    .outReady(outReady), .aluResult(aluResult), .zeroFlag(zeroFlag),
    .branchTarget(branchTarget), .branchTaken(branchTaken), .writeDataOut(writeDataOut),
    .writeRegOut(writeRegOut), .regWriteOut(regWriteOut), .memReadOut(memReadOut),
    .memWriteOut(memWriteOut)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct packed {
    logic [31:0] res;
    logic        zero;
    logic [31:0] tgt;
    logic        taken;
    logic [31:0] wd;
    logic [4:0]  wr;
    logic        rw, mr, mw;
  } slot_t;

  // Architectural result of the instruction currently on the inputs.
  function automatic slot_t model_op();
    slot_t       s;
    int          sh;
    logic [63:0] prod;
    s    = '0;
    sh   = int'(readData2[5:0]);
    prod = 64'(readData1) * 64'(readData2);
    case (aluOp)
      4'b0000: s.res = readData1 & readData2;
      4'b0001: s.res = readData1 | readData2;
      4'b0010: s.res = readData1 + readData2;
      4'b0110: s.res = readData1 - readData2;
      4'b0111: s.res = readData2;
      4'b1000: s.res = prod[31:0];
      4'b1001: s.res = (sh >= W) ? 32'd0 : readData1 << sh;
      4'b1010: s.res = (sh >= W) ? 32'd0 : readData1 >> sh;
      4'b1011: s.res = readData1 ^ readData2;
      default: s.res = 32'd0;
    endcase
    s.zero  = (s.res == 32'd0);
    s.tgt   = pcCurrent + pcOffsetFilled * 32'd4;
    s.taken = uncondBranchIn | (branchIn & s.zero);
    s.wd    = writeDataIn;
    s.wr    = writeRegIn;
    s.rw    = regWriteIn;
    s.mr    = memReadIn;
    s.mw    = memWriteIn;
    return s;
  endfunction

  slot_t m_slot = '0;
  slot_t m_pend = '0;
  bit    m_valid = 0;
  bit    m_busy = 0;
  int    m_cycles = 0;
  bit    m_free, m_consumed, m_fire;

  always @(posedge clock or negedge resetN) begin
    if (!resetN) begin
      m_slot   = '0;
      m_valid  = 0;
      m_busy   = 0;
      m_cycles = 0;
    end else begin
      m_free     = !m_valid || outReady;
      m_consumed = m_valid && outReady;
      m_fire     = inValid && !m_busy && m_free;
      if (m_busy) begin
        m_cycles++;
        if (m_cycles >= W && m_free) begin
          m_slot  = m_pend;
          m_valid = 1;
          m_busy  = 0;
        end else if (m_consumed) begin
          m_valid = 0;
        end
      end else if (m_fire) begin
        if (aluOp == 4'b1000) begin
          m_pend   = model_op();
          m_busy   = 1;
          m_cycles = 0;
          if (m_consumed) m_valid = 0;
        end else begin
          m_slot  = model_op();
          m_valid = 1;
        end
      end else if (m_consumed) begin
        m_valid = 0;
      end
    end
  end

  always @(negedge clock) begin
    check("inReady", 64'(inReady), 64'(resetN && !m_busy && (!m_valid || outReady)));
    check("outValid", 64'(outValid), 64'(m_valid));
    check("aluResult", 64'(aluResult), 64'(m_slot.res));
    check("zeroFlag", 64'(zeroFlag), 64'(m_slot.zero));
    check("branchTarget", 64'(branchTarget), 64'(m_slot.tgt));
    check("branchTaken", 64'(branchTaken), 64'(m_slot.taken));
    check("writeDataOut", 64'(writeDataOut), 64'(m_slot.wd));
    check("writeRegOut", 64'(writeRegOut), 64'(m_slot.wr));
    check("ctrlOut", 64'({regWriteOut, memReadOut, memWriteOut}),
          64'({m_slot.rw, m_slot.mr, m_slot.mw}));
  end

  task automatic set_in(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] pc, input logic [31:0] off, input logic [4:0] ctl,
                        input logic [31:0] wd, input logic [4:0] wr);
    aluOp = op; readData1 = a; readData2 = b; pcCurrent = pc; pcOffsetFilled = off;
    {regWriteIn, memReadIn, memWriteIn, branchIn, uncondBranchIn} = ctl;
    writeDataIn = wd; writeRegIn = wr;
    inValid = 1'b1;
  endtask

  // Presents one instruction and returns 1ns after the edge that accepts it.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic [31:0] pc = 0, input logic [31:0] off = 0,
                      input logic [4:0] ctl = 0, input logic [31:0] wd = 0,
                      input logic [4:0] wr = 0);
    bit got = 0;
    set_in(op, a, b, pc, off, ctl, wd, wr);
    for (int i = 0; i < 200; i++) begin
      @(negedge clock);
      if (inReady) begin
        got = 1;
        break;
      end
    end
    if (!got) check("accept_timeout", 64'(got), 64'd1);
    @(posedge clock);
    #1 inValid = 1'b0;
  endtask

  // Waits for outValid and returns the cycles elapsed since the accepting edge, or -1.
  task automatic wait_valid(output int lat);
    lat = -1;
    for (int i = 1; i <= 100; i++) begin
      @(negedge clock);
      if (outValid) begin
        lat = i - 1;
        break;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;

    repeat (2) @(posedge clock);
    @(negedge clock);
    check("rst_outValid", 64'(outValid), 64'd0);
    check("rst_inReady", 64'(inReady), 64'd0);
    @(posedge clock);
    #3 resetN = 1'b1;
    @(posedge clock);
    #1;

    send(4'b0010, 32'h7FFF_FFFF, 32'h1);
    check("add_valid", 64'(outValid), 64'd1);
    check("add_res", 64'(aluResult), 64'h8000_0000);
    check("add_zero", 64'(zeroFlag), 64'd0);

    send(4'b0110, 32'd5, 32'd5, 32'h100, 32'hFFFF_FFFE, 5'b00010);
    check("sub_res", 64'(aluResult), 64'd0);
    check("sub_zero", 64'(zeroFlag), 64'd1);
    check("sub_taken", 64'(branchTaken), 64'd1);
    check("sub_target", 64'(branchTarget), 64'h0F8);

    send(4'b1000, 32'h0000_FFFF, 32'h0001_0001);
    wait_valid(lat);
    check("mul_latency", 64'(lat), 64'd32);
    check("mul_res", 64'(aluResult), 64'hFFFF_FFFF);
    #1;

    send(4'b1001, 32'd1, 32'd31);
    check("lsl31", 64'(aluResult), 64'h8000_0000);
    send(4'b1001, 32'd1, 32'd32);
    check("lsl32", 64'(aluResult), 64'd0);
    send(4'b1010, 32'h8000_0000, 32'd31);
    check("lsr31", 64'(aluResult), 64'd1);
    send(4'b1010, 32'hF000_000F, 32'd63);
    check("lsr63", 64'(aluResult), 64'd0);

    send(4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 32'h40, 32'h3, 5'b10000, 32'hDEAD, 5'd7);
    check("and_res", 64'(aluResult), 64'h00F0_1200);
    send(4'b0001, 32'hF000_0000, 32'h0000_000F);
    check("orr_res", 64'(aluResult), 64'hF000_000F);
    send(4'b1011, 32'hFFFF_0000, 32'hFF00_FF00);
    check("eor_res", 64'(aluResult), 64'h00FF_FF00);
    send(4'b0111, 32'h1234, 32'd0, 32'h200, 32'd4, 5'b00010);
    check("passb_taken", 64'(branchTaken), 64'd1);
    check("passb_target", 64'(branchTarget), 64'h210);
    send(4'b0011, 32'h55, 32'hAA, 32'h0, 32'h0, 5'b10101, 32'hCAFE_F00D, 5'd19);
    check("undef_res", 64'(aluResult), 64'd0);
    check("undef_zero", 64'(zeroFlag), 64'd1);
    check("undef_wd", 64'(writeDataOut), 64'hCAFE_F00D);
    check("undef_taken", 64'(branchTaken), 64'd1);
    send(4'b0110, 32'd3, 32'd5, 32'h0, 32'h0, 5'b01001);
    check("sub_wrap", 64'(aluResult), 64'hFFFF_FFFE);

    // Stall: slot held while downstream is not ready, queued op waits.
    send(4'b0010, 32'd10, 32'd20);
    outReady = 1'b0;
    set_in(4'b0110, 32'd100, 32'd1, 32'h0, 32'h0, 5'b0, 32'h0, 5'd0);
    repeat (5) begin
      @(negedge clock);
      check("stall_inReady", 64'(inReady), 64'd0);
      check("stall_res", 64'(aluResult), 64'd30);
    end
    #1 outReady = 1'b1;
    @(posedge clock);
    #1 inValid = 1'b0;
    check("unstall_valid", 64'(outValid), 64'd1);
    check("unstall_res", 64'(aluResult), 64'd99);

    // Multiply whose result is then held by a stalled consumer.
    send(4'b1000, 32'd7, 32'd6);
    outReady = 1'b0;
    wait_valid(lat);
    check("mul2_latency", 64'(lat), 64'd32);
    check("mul2_res", 64'(aluResult), 64'd42);
    repeat (3) @(negedge clock);
    #1 outReady = 1'b1;
    @(posedge clock);
    #1;

    // Reset in the middle of an iteration.
    send(4'b1000, 32'h1234, 32'h5678);
    repeat (10) @(posedge clock);
    #2 resetN = 1'b0;
    #1;
    check("rstmul_valid", 64'(outValid), 64'd0);
    check("rstmul_ready", 64'(inReady), 64'd0);
    check("rstmul_res", 64'(aluResult), 64'd0);
    check("rstmul_wd", 64'(writeDataOut), 64'd0);
    @(posedge clock);
    @(posedge clock);
    #3 resetN = 1'b1;
    @(negedge clock);
    check("rstmul_ready_after", 64'(inReady), 64'd1);
    seen = 0;
    repeat (40) begin
      @(negedge clock);
      if (outValid) seen = 1;
    end
    check("rstmul_no_pulse", 64'(seen), 64'd0);

    send(4'b0010, 32'd2, 32'd3);
    check("post_rst_add", 64'(aluResult), 64'd5);
    repeat (2) @(posedge clock);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
